// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// byte-enable constants and the read-modify-write byte merge.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WB   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  // Enabled bytes come from the new data, the others from the word already in DM.
  function automatic logic [31:0] be_merge(input logic [31:0] new_w,
                                           input logic [31:0] old_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[k*8 +: 8] = new_w[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: packed per-requester request
// fields towards the arbiter, one-hot grant/done and shared read data back.
interface dm_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 10,
  parameter int DW   = 32
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ*4-1:0]  be;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               busy;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, done, rdata, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, done, rdata, busy
  );

endinterface

// File: rtl/dm_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping around to bit 0.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    int j;
    winner = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    // Scan from lowest to highest priority so the highest-priority hit lands last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        winner    = '0;
        winner[j] = 1'b1;
        idx       = IW'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing a single-port word memory between NREQ
// requesters; partial-byte stores become a read-modify-write.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 10,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  dm_arbiter_if.slave   bus,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_wr,
  input  logic [DW-1:0] dm_dout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] win_q;
  logic            we_q;
  logic [3:0]      be_q;
  logic [DW-1:0]   wdata_q;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [3:0]      sel_be;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .winner (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_we    = bus.we[i];
        sel_addr  = bus.addr[i*AW +: AW];
        sel_wdata = bus.wdata[i*DW +: DW];
        sel_be    = bus.be[i*4 +: 4];
      end
    end
  end

  // Decoded from state so an asynchronous reset kills a write in the same instant.
  assign dm_wr = (state == WB) || ((state == ACC) && we_q && (be_q == BE_FULL));

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win_q     <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      dm_addr   <= '0;
      dm_din    <= '0;
      bus.gnt   <= '0;
      bus.done  <= '0;
      bus.rdata <= '0;
      bus.busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= ACC;
            bus.gnt  <= pick_oh;
            bus.busy <= 1'b1;
            win_q    <= pick_oh;
            rr_ptr   <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
            we_q     <= sel_we;
            be_q     <= sel_be;
            wdata_q  <= sel_wdata;
            dm_addr  <= sel_addr;
            if (sel_we && (sel_be == BE_FULL)) dm_din <= sel_wdata;
          end
        end
        ACC: begin
          bus.gnt   <= '0;
          bus.rdata <= dm_dout;
          // dm_din doubles as the merge buffer written back during WB.
          if (we_q && (be_q != BE_FULL) && (be_q != BE_NONE)) begin
            dm_din <= be_merge(wdata_q, dm_dout, be_q);
            state  <= WB;
          end else begin
            bus.done <= win_q;
            state    <= RESP;
          end
        end
        WB: begin
          bus.done <= win_q;
          state    <= RESP;
        end
        RESP: begin
          bus.done <= '0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
